store_data_queue: RTL and testbench

In-order circular store queue for the LSU. Dispatch allocates an entry per store. Exec fills in address, data and byte mask. The ROB commits stores in order, and committed entries drain from the head to the data cache. The block publishes a wrap-tagged tail marker that loads capture at dispatch. It also answers a same-cycle disambiguation and forwarding query for the load queue's issued load.

---
 rtl/store_data_queue_if.sv | 50 +++++
 rtl/store_data_queue.sv | 155 +++++++++++++++
 tb/tb_store_data_queue.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_data_queue_if.sv
// Store data queue port bundle: dispatch, exec, commit/flush, cache drain and load query.
// slave = the queue itself, master = the LSU logic around it.
interface store_data_queue_if #(
  parameter int SDQ_ENTRIES = 8
);
  localparam int PW = $clog2(SDQ_ENTRIES) + 1;

  logic          disp_vld;
  logic          disp_full;
  logic [PW-2:0] disp_sdq_idx;
  logic [PW-1:0] sdq_tail;

  logic          exec_vld;
  logic [PW-2:0] exec_sdq_idx;
  logic [31:0]   exec_addr;
  logic [31:0]   exec_data;
  logic [3:0]    exec_mask;

  logic          commit_vld;
  logic          flush_vld;

  // mem_req_* is a valid/ready handshake: a request transfers on a cycle where
  // mem_req_vld && mem_req_rdy; while vld is high and rdy low, addr/data/mask hold.
  logic          mem_req_vld;
  logic [31:0]   mem_req_addr;
  logic [31:0]   mem_req_data;
  logic [3:0]    mem_req_mask;
  logic          mem_req_rdy;

  logic          ld_vld;
  logic [31:0]   ld_addr;
  logic [PW-1:0] ld_marker;
  logic          ld_stall;
  logic          ld_fwd_hit;
  logic [31:0]   ld_fwd_data;

  modport slave (
    input  disp_vld, exec_vld, exec_sdq_idx, exec_addr, exec_data, exec_mask,
           commit_vld, flush_vld, mem_req_rdy, ld_vld, ld_addr, ld_marker,
    output disp_full, disp_sdq_idx, sdq_tail, mem_req_vld, mem_req_addr,
           mem_req_data, mem_req_mask, ld_stall, ld_fwd_hit, ld_fwd_data
  );

  modport master (
    output disp_vld, exec_vld, exec_sdq_idx, exec_addr, exec_data, exec_mask,
           commit_vld, flush_vld, mem_req_rdy, ld_vld, ld_addr, ld_marker,
    input  disp_full, disp_sdq_idx, sdq_tail, mem_req_vld, mem_req_addr,
           mem_req_data, mem_req_mask, ld_stall, ld_fwd_hit, ld_fwd_data
  );
endinterface

// File: rtl/store_data_queue.sv
// In-order circular store queue with commit/drain, flush and load disambiguation.
// Define SDQ_FWD_EN to enable full-word store-to-load forwarding.
module store_data_queue #(
  parameter int SDQ_ENTRIES = 8
) (
  input logic               clk,
  input logic               rst,
  store_data_queue_if.slave sdq
);
  localparam int N  = SDQ_ENTRIES;
  localparam int PW = $clog2(SDQ_ENTRIES) + 1;
  localparam int IW = PW - 1;

  logic [N-1:0]  valid_q, addr_valid_q, committed_q;
  logic [29:0]   addr_q [N];
  logic [31:0]   data_q [N];
  logic [3:0]    mask_q [N];
  logic [PW-1:0] head_q, cmt_q, tail_q, count_q;

  logic [IW-1:0] head_idx, cmt_idx, tail_idx;
  logic          do_alloc, do_drain, do_exec;
  logic [PW-1:0] head_nxt, cmt_nxt, flush_span;
  logic [N-1:0]  flush_kill;
  logic          unused_bits;

  function automatic logic [PW-1:0] ring_dist(input logic [IW-1:0] from, input int slot);
    return {1'b0, IW'(slot) - from};
  endfunction

  assign head_idx = head_q[IW-1:0];
  assign cmt_idx  = cmt_q[IW-1:0];
  assign tail_idx = tail_q[IW-1:0];

  assign sdq.disp_full    = (count_q == PW'(N));
  assign sdq.disp_sdq_idx = tail_idx;
  assign sdq.sdq_tail     = tail_q;

  assign sdq.mem_req_vld  = valid_q[head_idx] & committed_q[head_idx];
  assign sdq.mem_req_addr = {addr_q[head_idx], 2'b00};
  assign sdq.mem_req_data = data_q[head_idx];
  assign sdq.mem_req_mask = mask_q[head_idx];

  assign do_alloc   = sdq.disp_vld & ~sdq.disp_full & ~sdq.flush_vld;
  assign do_drain   = sdq.mem_req_vld & sdq.mem_req_rdy;
  assign do_exec    = sdq.exec_vld & valid_q[sdq.exec_sdq_idx];
  assign head_nxt   = head_q + PW'(do_drain);
  assign cmt_nxt    = cmt_q + PW'(sdq.commit_vld);
  assign flush_span = tail_q - cmt_nxt;

  assign unused_bits = ^{sdq.ld_addr[1:0], sdq.exec_addr[1:0]};

  // A flush keeps everything older than the post-commit pointer and kills the rest.
  always_comb begin
    flush_kill = '0;
    for (int i = 0; i < N; i++) begin
      flush_kill[i] = sdq.flush_vld && (ring_dist(cmt_nxt[IW-1:0], i) < flush_span);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      addr_valid_q <= '0;
      committed_q  <= '0;
      head_q       <= '0;
      cmt_q        <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else begin
      head_q <= head_nxt;
      cmt_q  <= cmt_nxt;
      if (sdq.flush_vld) begin
        tail_q  <= cmt_nxt;
        count_q <= cmt_nxt - head_nxt;
      end else begin
        tail_q  <= tail_q + PW'(do_alloc);
        count_q <= count_q + PW'(do_alloc) - PW'(do_drain);
      end
      for (int i = 0; i < N; i++) begin
        if (do_alloc && (tail_idx == IW'(i))) begin
          valid_q[i]      <= 1'b1;
          addr_valid_q[i] <= 1'b0;
          committed_q[i]  <= 1'b0;
        end
        if (do_exec && (sdq.exec_sdq_idx == IW'(i))) addr_valid_q[i] <= 1'b1;
        if (sdq.commit_vld && (cmt_idx == IW'(i))) committed_q[i] <= 1'b1;
        if ((do_drain && (head_idx == IW'(i))) || flush_kill[i]) valid_q[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_exec) begin
      addr_q[sdq.exec_sdq_idx] <= sdq.exec_addr[31:2];
      data_q[sdq.exec_sdq_idx] <= sdq.exec_data;
      mask_q[sdq.exec_sdq_idx] <= sdq.exec_mask;
    end
  end

  logic [PW-1:0] ld_span;
  logic [IW-1:0] q_idx;
  logic          any_unknown, match_found;
`ifdef SDQ_FWD_EN
  logic          match_full;
  logic [31:0]   match_data;
`endif

  always_comb begin
    ld_span     = sdq.ld_marker - head_q;
    q_idx       = '0;
    any_unknown = 1'b0;
    match_found = 1'b0;
`ifdef SDQ_FWD_EN
    match_full  = 1'b0;
    match_data  = '0;
`endif
    // Walk oldest to youngest so the last hit is the youngest older match.
    for (int d = 0; d < N; d++) begin
      q_idx = head_idx + IW'(d);
      if (valid_q[q_idx] && (PW'(d) < ld_span)) begin
        if (!addr_valid_q[q_idx]) begin
          any_unknown = 1'b1;
        end else if (addr_q[q_idx] == sdq.ld_addr[31:2]) begin
          match_found = 1'b1;
`ifdef SDQ_FWD_EN
          match_full  = (mask_q[q_idx] == 4'hF);
          match_data  = data_q[q_idx];
`endif
        end
      end
    end
  end

  always_comb begin
    sdq.ld_stall    = 1'b0;
    sdq.ld_fwd_hit  = 1'b0;
    sdq.ld_fwd_data = '0;
    if (sdq.ld_vld) begin
      if (any_unknown) begin
        sdq.ld_stall = 1'b1;
      end else if (match_found) begin
`ifdef SDQ_FWD_EN
        if (match_full) begin
          sdq.ld_fwd_hit  = 1'b1;
          sdq.ld_fwd_data = match_data;
        end else begin
          sdq.ld_stall = 1'b1;
        end
`else
        sdq.ld_stall = 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_store_data_queue.sv
// Bench for store_data_queue: directed scenarios plus a randomized run checked
// against a sequence-numbered queue model and a drain scoreboard.
`timescale 1ns/1ps
module tb_store_data_queue;
  localparam int N  = 8;
  localparam int PW = $clog2(N) + 1;
  localparam int IW = PW - 1;
  localparam int M2 = 2 * N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_data_queue_if #(.SDQ_ENTRIES(N)) sdq ();
  store_data_queue #(.SDQ_ENTRIES(N)) dut (.clk(clk), .rst(rst), .sdq(sdq));

  typedef struct packed {
    logic        av;
    logic        cm;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } st_t;

  // Model: mq[0] is the oldest store; m_head is its absolute sequence number.
  st_t         mq[$];
  int          m_head;
  int          m_ncmt;
  logic [67:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  // ---------------- drivers ----------------
  task automatic idle();
    sdq.disp_vld = 0; sdq.exec_vld = 0; sdq.exec_sdq_idx = '0;
    sdq.exec_addr = '0; sdq.exec_data = '0; sdq.exec_mask = '0;
    sdq.commit_vld = 0; sdq.flush_vld = 0; sdq.mem_req_rdy = 0;
    sdq.ld_vld = 0; sdq.ld_addr = '0; sdq.ld_marker = '0;
  endtask

  task automatic model_reset();
    mq.delete(); exp_q.delete();
    m_head = 0; m_ncmt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drive_exec(input int slot, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    sdq.exec_vld = 1; sdq.exec_sdq_idx = IW'(slot);
    sdq.exec_addr = a; sdq.exec_data = d; sdq.exec_mask = m;
  endtask

  task automatic drive_query(input int seq, input logic [31:0] a);
    sdq.ld_vld = 1; sdq.ld_addr = a; sdq.ld_marker = PW'(seq % M2);
  endtask

  // Advance the model by the inputs presented this cycle.
  task automatic model_apply();
    bit  full, drain, alloc;
    int  k;
    st_t e;
    full  = (mq.size() == N);
    drain = (mq.size() > 0) && mq[0].cm && sdq.mem_req_rdy;
    alloc = sdq.disp_vld && !full && !sdq.flush_vld;
    if (sdq.exec_vld) begin
      k = (int'(sdq.exec_sdq_idx) - (m_head % N) + N) % N;
      if (k < mq.size()) begin
        e = mq[k]; e.av = 1; e.a = sdq.exec_addr; e.d = sdq.exec_data; e.m = sdq.exec_mask;
        mq[k] = e;
      end
    end
    if (sdq.commit_vld && (m_ncmt < mq.size())) begin
      e = mq[m_ncmt]; e.cm = 1; mq[m_ncmt] = e;
      exp_q.push_back({e.a[31:2], 2'b00, e.d, e.m});
      m_ncmt++;
    end
    if (sdq.flush_vld) while (mq.size() > m_ncmt) void'(mq.pop_back());
    if (drain) begin
      void'(mq.pop_front()); m_head++; m_ncmt--;
    end
    if (alloc) begin
      e = '0; mq.push_back(e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_apply();
    @(posedge clk); #1;
  endtask

  function automatic void model_query(input int seq, input logic [31:0] a,
                                      output logic st, output logic hit, output logic [31:0] d);
    int n;
    int found;
    bit unk;
    st = 0; hit = 0; d = '0; found = -1; unk = 0;
    n = seq - m_head;
    if (n > mq.size()) n = mq.size();
    for (int k = 0; k < n; k++) begin
      if (!mq[k].av) unk = 1;
      else if (mq[k].a[31:2] == a[31:2]) found = k;
    end
    if (unk) st = 1;
    else if (found >= 0) begin
`ifdef SDQ_FWD_EN
      if (mq[found].m == 4'hF) begin hit = 1; d = mq[found].d; end
      else st = 1;
`else
      st = 1;
`endif
    end
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    drive_query(0, 32'h100);
    #1;
    n_checks++; if (sdq.disp_full !== 1'b0) begin n_fail++; $display("FAIL reset_disp_full: got %0b want 0", sdq.disp_full); end
    n_checks++; if (sdq.sdq_tail !== '0) begin n_fail++; $display("FAIL reset_sdq_tail: got %0d want 0", sdq.sdq_tail); end
    n_checks++; if (sdq.disp_sdq_idx !== '0) begin n_fail++; $display("FAIL reset_disp_idx: got %0d want 0", sdq.disp_sdq_idx); end
    n_checks++; if (sdq.mem_req_vld !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_vld: got %0b want 0", sdq.mem_req_vld); end
    n_checks++; if (sdq.ld_stall !== 1'b0) begin n_fail++; $display("FAIL reset_ld_stall: got %0b want 0", sdq.ld_stall); end
    n_checks++; if (sdq.ld_fwd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_ld_fwd_hit: got %0b want 0", sdq.ld_fwd_hit); end
    n_checks++; if (sdq.ld_fwd_data !== 32'h0) begin n_fail++; $display("FAIL reset_ld_fwd_data: got %h want 0", sdq.ld_fwd_data); end
    idle();
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < N; i++) begin
      sdq.disp_vld = 1; #1;
      n_checks++; if (sdq.disp_sdq_idx !== IW'(i)) begin n_fail++; $display("FAIL fill_idx[%0d]: got %0d want %0d", i, sdq.disp_sdq_idx, i); end
      n_checks++; if (sdq.disp_full !== 1'b0) begin n_fail++; $display("FAIL fill_not_full[%0d]: got %0b want 0", i, sdq.disp_full); end
      tick();
    end
    n_checks++; if (sdq.sdq_tail !== PW'(N)) begin n_fail++; $display("FAIL fill_tail: got %0d want %0d", sdq.sdq_tail, N); end
    n_checks++; if (sdq.disp_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %0b want 1", sdq.disp_full); end
    tick();  // ninth dispatch must be dropped
    n_checks++; if (sdq.sdq_tail !== PW'(N)) begin n_fail++; $display("FAIL fill_ninth_tail: got %0d want %0d", sdq.sdq_tail, N); end
    idle();
    drive_exec(0, 32'h700, 32'h77, 4'hF); tick(); idle();
    sdq.commit_vld = 1; tick(); idle();
    // Drain while full: full stays high this cycle, slot is usable next cycle.
    sdq.disp_vld = 1; sdq.mem_req_rdy = 1; #1;
    n_checks++; if (sdq.mem_req_vld !== 1'b1) begin n_fail++; $display("FAIL full_drain_vld: got %0b want 1", sdq.mem_req_vld); end
    n_checks++; if (sdq.mem_req_addr !== 32'h700) begin n_fail++; $display("FAIL full_drain_addr: got %h want 700", sdq.mem_req_addr); end
    n_checks++; if (sdq.disp_full !== 1'b1) begin n_fail++; $display("FAIL full_drain_full: got %0b want 1", sdq.disp_full); end
    tick();
    sdq.mem_req_rdy = 0; #1;
    n_checks++; if (sdq.sdq_tail !== PW'(N)) begin n_fail++; $display("FAIL full_drain_tail: got %0d want %0d", sdq.sdq_tail, N); end
    n_checks++; if (sdq.disp_full !== 1'b0) begin n_fail++; $display("FAIL full_after_drain: got %0b want 0", sdq.disp_full); end
    tick();
    n_checks++; if (sdq.sdq_tail !== PW'(N + 1)) begin n_fail++; $display("FAIL full_realloc_tail: got %0d want %0d", sdq.sdq_tail, N + 1); end
    n_checks++; if (sdq.disp_full !== 1'b1) begin n_fail++; $display("FAIL full_realloc_full: got %0b want 1", sdq.disp_full); end
    idle();
  endtask

  task automatic test_drain();
    logic [67:0] e;
    do_reset();
    sdq.disp_vld = 1; tick(); idle();
    drive_exec(0, 32'h100, 32'hDEADBEEF, 4'hF); tick(); idle();
    sdq.commit_vld = 1; #1;
    n_checks++; if (sdq.mem_req_vld !== 1'b0) begin n_fail++; $display("FAIL drain_commit_cycle_vld: got %0b want 0", sdq.mem_req_vld); end
    tick(); idle();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (sdq.mem_req_vld !== 1'b1 || sdq.mem_req_addr !== 32'h100) begin n_fail++; $display("FAIL drain_hold[%0d]: got vld %0b addr %h want 1 100", i, sdq.mem_req_vld, sdq.mem_req_addr); end
      tick();
    end
    sdq.mem_req_rdy = 1; #1;
    e = exp_q.size() ? exp_q.pop_front() : '0;
    n_checks++; if ({sdq.mem_req_vld, sdq.mem_req_addr, sdq.mem_req_data, sdq.mem_req_mask} !== {1'b1, e})
      begin n_fail++; $display("FAIL drain_req: got %0b %h %h %h want 1 %h", sdq.mem_req_vld, sdq.mem_req_addr, sdq.mem_req_data, sdq.mem_req_mask, e); end
    n_checks++; if (e !== {32'h100, 32'hDEADBEEF, 4'hF}) begin n_fail++; $display("FAIL drain_scoreboard: got %h want 100 deadbeef f", e); end
    tick(); idle(); #1;
    n_checks++; if (sdq.mem_req_vld !== 1'b0) begin n_fail++; $display("FAIL drain_after_vld: got %0b want 0", sdq.mem_req_vld); end
    // Head and count moved: a full N further allocations are accepted.
    sdq.disp_vld = 1;
    for (int i = 0; i < N - 1; i++) tick();
    n_checks++; if (sdq.disp_full !== 1'b0) begin n_fail++; $display("FAIL drain_count_n1: got %0b want 0", sdq.disp_full); end
    tick();
    n_checks++; if (sdq.disp_full !== 1'b1 || sdq.sdq_tail !== PW'(N + 1)) begin n_fail++; $display("FAIL drain_count_n: got full %0b tail %0d want 1 %0d", sdq.disp_full, sdq.sdq_tail, N + 1); end
    idle();
  endtask

  task automatic test_forward();
    do_reset();
    sdq.disp_vld = 1; tick(); idle();
    drive_query(1, 32'h100); #1;
    n_checks++; if (sdq.ld_stall !== 1'b1 || sdq.ld_fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_unknown_addr: got stall %0b hit %0b want 1 0", sdq.ld_stall, sdq.ld_fwd_hit); end
    drive_exec(0, 32'h100, 32'hDEADBEEF, 4'hF); #1;
    n_checks++; if (sdq.ld_stall !== 1'b1) begin n_fail++; $display("FAIL fwd_no_bypass: got stall %0b want 1", sdq.ld_stall); end
    tick(); idle();
    drive_query(1, 32'h102); #1;
`ifdef SDQ_FWD_EN
    n_checks++; if ({sdq.ld_stall, sdq.ld_fwd_hit, sdq.ld_fwd_data} !== {2'b01, 32'hDEADBEEF}) begin n_fail++; $display("FAIL fwd_word: got stall %0b hit %0b data %h want 0 1 deadbeef", sdq.ld_stall, sdq.ld_fwd_hit, sdq.ld_fwd_data); end
`else
    n_checks++; if ({sdq.ld_stall, sdq.ld_fwd_hit, sdq.ld_fwd_data} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL fwd_off_stall: got stall %0b hit %0b data %h want 1 0 0", sdq.ld_stall, sdq.ld_fwd_hit, sdq.ld_fwd_data); end
`endif
    sdq.ld_vld = 0; #1;
    n_checks++; if ({sdq.ld_stall, sdq.ld_fwd_hit, sdq.ld_fwd_data} !== 34'h0) begin n_fail++; $display("FAIL fwd_ld_vld_low: got stall %0b hit %0b data %h want 0 0 0", sdq.ld_stall, sdq.ld_fwd_hit, sdq.ld_fwd_data); end
    drive_query(0, 32'h100); #1;
    n_checks++; if (sdq.ld_stall !== 1'b0 || sdq.ld_fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_marker_eq_head: got stall %0b hit %0b want 0 0", sdq.ld_stall, sdq.ld_fwd_hit); end
    idle();
    sdq.disp_vld = 1; tick(); tick(); idle();
    drive_exec(1, 32'h200, 32'h11, 4'hF); tick();
    drive_exec(2, 32'h200, 32'h22, 4'hF); tick(); idle();
    drive_query(3, 32'h200); #1;
`ifdef SDQ_FWD_EN
    n_checks++; if (sdq.ld_fwd_hit !== 1'b1 || sdq.ld_fwd_data !== 32'h22) begin n_fail++; $display("FAIL fwd_youngest: got hit %0b data %h want 1 22", sdq.ld_fwd_hit, sdq.ld_fwd_data); end
`else
    n_checks++; if (sdq.ld_stall !== 1'b1 || sdq.ld_fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_off_youngest: got stall %0b hit %0b want 1 0", sdq.ld_stall, sdq.ld_fwd_hit); end
`endif
    drive_query(2, 32'h200); #1;
`ifdef SDQ_FWD_EN
    n_checks++; if (sdq.ld_fwd_hit !== 1'b1 || sdq.ld_fwd_data !== 32'h11) begin n_fail++; $display("FAIL fwd_marker_limit: got hit %0b data %h want 1 11", sdq.ld_fwd_hit, sdq.ld_fwd_data); end
`else
    n_checks++; if (sdq.ld_stall !== 1'b1) begin n_fail++; $display("FAIL fwd_off_marker_limit: got stall %0b want 1", sdq.ld_stall); end
`endif
    drive_query(1, 32'h200); #1;
    n_checks++; if (sdq.ld_stall !== 1'b0 || sdq.ld_fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_younger_ignored: got stall %0b hit %0b want 0 0", sdq.ld_stall, sdq.ld_fwd_hit); end
    idle();
    sdq.disp_vld = 1; tick(); idle();
    drive_exec(3, 32'h300, 32'h33, 4'h3); tick(); idle();
    drive_query(4, 32'h300); #1;
    n_checks++; if (sdq.ld_stall !== 1'b1 || sdq.ld_fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_partial_mask: got stall %0b hit %0b want 1 0", sdq.ld_stall, sdq.ld_fwd_hit); end
    drive_query(4, 32'h304); #1;
    n_checks++; if (sdq.ld_stall !== 1'b0 || sdq.ld_fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_no_match: got stall %0b hit %0b want 0 0", sdq.ld_stall, sdq.ld_fwd_hit); end
    idle();
  endtask

  task automatic test_flush();
    int          n_req;
    logic [67:0] e;
    do_reset();
    sdq.disp_vld = 1;
    for (int i = 0; i < 5; i++) tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      drive_exec(i, 32'h600 + 32'(4 * i), 32'(i + 1), 4'hF); tick();
    end
    idle();
    sdq.commit_vld = 1; tick(); tick(); idle();
    sdq.flush_vld = 1; sdq.disp_vld = 1; tick(); idle(); #1;
    n_checks++; if (sdq.sdq_tail !== PW'(2) || sdq.disp_sdq_idx !== IW'(2)) begin n_fail++; $display("FAIL flush_tail: got tail %0d idx %0d want 2 2", sdq.sdq_tail, sdq.disp_sdq_idx); end
    n_checks++; if (sdq.disp_full !== 1'b0) begin n_fail++; $display("FAIL flush_full: got %0b want 0", sdq.disp_full); end
    drive_query(5, 32'h60C); #1;
    n_checks++; if (sdq.ld_stall !== 1'b0 || sdq.ld_fwd_hit !== 1'b0) begin n_fail++; $display("FAIL flush_killed_entry: got stall %0b hit %0b want 0 0", sdq.ld_stall, sdq.ld_fwd_hit); end
    idle();
    sdq.mem_req_rdy = 1; n_req = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (sdq.mem_req_vld) begin
        n_req++;
        e = exp_q.size() ? exp_q.pop_front() : '1;
        n_checks++; if ({sdq.mem_req_addr, sdq.mem_req_data, sdq.mem_req_mask} !== e) begin n_fail++; $display("FAIL flush_drain_req: got %h %h %h want %h", sdq.mem_req_addr, sdq.mem_req_data, sdq.mem_req_mask, e); end
      end
      tick();
    end
    n_checks++; if (n_req !== 2) begin n_fail++; $display("FAIL flush_drain_count: got %0d want 2", n_req); end
    idle();
  endtask

  task automatic test_random_wrap();
    int          ld_seq, k, slot, n_drained;
    logic        e_st, e_hit;
    logic [31:0] e_d;
    logic [67:0] e;
    st_t         h;
    do_reset();
    n_drained = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle();
      sdq.disp_vld = ($urandom_range(0, 99) < 60);
      slot = $urandom_range(0, N - 1);
      k = (slot - (m_head % N) + N) % N;
      if (($urandom_range(0, 99) < 50) && ((k >= mq.size()) || !mq[k].cm)) begin
        case ($urandom_range(0, 2))
          0:       drive_exec(slot, 32'h400 + 32'($urandom_range(0, 15)), $urandom, 4'hF);
          1:       drive_exec(slot, 32'h400 + 32'($urandom_range(0, 15)), $urandom, 4'h3);
          default: drive_exec(slot, 32'h400 + 32'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
        endcase
      end
      sdq.commit_vld = (m_ncmt < mq.size()) && mq[m_ncmt].av && ($urandom_range(0, 99) < 50);
      sdq.flush_vld  = ($urandom_range(0, 99) < 3);
      sdq.mem_req_rdy = ($urandom_range(0, 99) < 60);
      ld_seq = m_head + int'($urandom_range(0, mq.size()));
      if ($urandom_range(0, 99) < 70) drive_query(ld_seq, 32'h400 + 32'($urandom_range(0, 15)));
      #1;
      n_checks++; if (sdq.sdq_tail !== PW'((m_head + mq.size()) % M2)) begin n_fail++; $display("FAIL rnd_tail[%0d]: got %0d want %0d", cyc, sdq.sdq_tail, (m_head + mq.size()) % M2); end
      n_checks++; if (sdq.disp_sdq_idx !== IW'((m_head + mq.size()) % N)) begin n_fail++; $display("FAIL rnd_idx[%0d]: got %0d want %0d", cyc, sdq.disp_sdq_idx, (m_head + mq.size()) % N); end
      n_checks++; if (sdq.disp_full !== (mq.size() == N)) begin n_fail++; $display("FAIL rnd_full[%0d]: got %0b want %0b", cyc, sdq.disp_full, mq.size() == N); end
      n_checks++; if (sdq.mem_req_vld !== ((mq.size() > 0) && mq[0].cm)) begin n_fail++; $display("FAIL rnd_mem_vld[%0d]: got %0b want %0b", cyc, sdq.mem_req_vld, (mq.size() > 0) && mq[0].cm); end
      if ((mq.size() > 0) && mq[0].cm) begin
        h = mq[0];
        n_checks++; if ({sdq.mem_req_addr, sdq.mem_req_data, sdq.mem_req_mask} !== {h.a[31:2], 2'b00, h.d, h.m}) begin n_fail++; $display("FAIL rnd_mem_req[%0d]: got %h %h %h want %h %h %h", cyc, sdq.mem_req_addr, sdq.mem_req_data, sdq.mem_req_mask, {h.a[31:2], 2'b00}, h.d, h.m); end
      end
      if (sdq.mem_req_vld && sdq.mem_req_rdy) begin
        n_drained++;
        e = exp_q.size() ? exp_q.pop_front() : '1;
        n_checks++; if ({sdq.mem_req_addr, sdq.mem_req_data, sdq.mem_req_mask} !== e) begin n_fail++; $display("FAIL rnd_scoreboard[%0d]: got %h %h %h want %h", cyc, sdq.mem_req_addr, sdq.mem_req_data, sdq.mem_req_mask, e); end
      end
      model_query(ld_seq, sdq.ld_addr, e_st, e_hit, e_d);
      if (!sdq.ld_vld) begin e_st = 0; e_hit = 0; e_d = '0; end
      n_checks++; if ({sdq.ld_stall, sdq.ld_fwd_hit, sdq.ld_fwd_data} !== {e_st, e_hit, e_d}) begin n_fail++; $display("FAIL rnd_query[%0d]: got stall %0b hit %0b data %h want %0b %0b %h", cyc, sdq.ld_stall, sdq.ld_fwd_hit, sdq.ld_fwd_data, e_st, e_hit, e_d); end
      tick();
    end
    idle();
    n_checks++; if (n_drained <= M2) begin n_fail++; $display("FAIL rnd_wrap: got %0d drains want more than %0d", n_drained, M2); end
    drive_query(m_head, 32'h400); #1;
    n_checks++; if (sdq.ld_stall !== 1'b0 || sdq.ld_fwd_hit !== 1'b0) begin n_fail++; $display("FAIL rnd_marker_eq_head: got stall %0b hit %0b want 0 0", sdq.ld_stall, sdq.ld_fwd_hit); end
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fill();
    test_drain();
    test_forward();
    test_flush();
    test_random_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
